// File: rtl/cam_pkg.sv
// Shared camera-path constants: decimator state encoding, source geometry
// and the frame-buffer size seen by the capture stage.
package cam_pkg;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    BLANK   = 2'd1,
    ACTIVE  = 2'd2,
    END     = 2'd3
  } cam_state_e;

  localparam int SRC_W_DEF = 640;
  localparam int SRC_H_DEF = 480;
  localparam int DEC_X_DEF = 4;
  localparam int DEC_Y_DEF = 4;
  localparam int CW_DEF    = 10;

  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int FB_SIZE = FB_W * FB_H;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cam_mod_counter.sv
// Down-counting wrap counter used as a cheap modulo-N phase:
// zero_o marks index % N == 0, term_o marks the value just after a wrap.
module cam_mod_counter
  import cam_pkg::*;
#(
  parameter int N = 4
) (
  input  logic CAM_pclk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic zero_o,
  output logic term_o
);

  localparam int W = cnt_width(N);
  localparam logic [W-1:0] MAX_C = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? MAX_C : cnt_q - W'(1);
    end
  end

  always_ff @(posedge CAM_pclk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign term_o = (cnt_q == MAX_C);

endmodule

// File: rtl/cam_decimator.sv
// Keeps every DEC_X-th pixel of every DEC_Y-th line of the raw RGB444
// camera stream and re-emits a clean, 1-cycle-delayed VSYNC/HREF/data stream.
module cam_decimator
  import cam_pkg::*;
#(
  parameter int SRC_W = SRC_W_DEF,
  parameter int SRC_H = SRC_H_DEF,
  parameter int DEC_X = DEC_X_DEF,
  parameter int DEC_Y = DEC_Y_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          CAM_pclk,
  input  logic          reset,
  input  logic [7:0]    in_px_data,
  input  logic          in_vsync,
  input  logic          in_href,
  output logic [7:0]    out_px_data,
  output logic          out_vsync,
  output logic          out_href,
  output logic          frame_done,
  output logic          frame_err,
  output logic [CW-1:0] line_idx,
  output logic [CW-1:0] pix_idx
);

  localparam logic [CW-1:0] W_C = CW'(SRC_W);
  localparam logic [CW-1:0] H_C = CW'(SRC_H);

  cam_state_e st_q, st_d;

  logic          phase_q, phase_d;
  logic          href_q;
  logic          vs_q;
  logic [7:0]    px_q, px_d;
  logic          oh_q, oh_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [CW-1:0] line_q, line_d;
  logic [CW-1:0] pix_q, pix_d;

  logic px_en, px_clr, px_zero, px_term;
  logic ln_en, ln_clr, ln_zero, ln_term;
  logic line_end;
  logic unused_term;

  cam_mod_counter #(.N(DEC_X)) u_px_cnt (
    .CAM_pclk (CAM_pclk),
    .reset    (reset),
    .en_i     (px_en),
    .clr_i    (px_clr),
    .zero_o   (px_zero),
    .term_o   (px_term)
  );

  cam_mod_counter #(.N(DEC_Y)) u_ln_cnt (
    .CAM_pclk (CAM_pclk),
    .reset    (reset),
    .en_i     (ln_en),
    .clr_i    (ln_clr),
    .zero_o   (ln_zero),
    .term_o   (ln_term)
  );

  assign unused_term = px_term ^ ln_term;
  assign line_end    = href_q & ~in_href;

  always_comb begin
    st_d    = st_q;
    phase_d = phase_q;
    px_d    = px_q;
    oh_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    line_d  = line_q;
    pix_d   = pix_q;
    px_en   = 1'b0;
    px_clr  = 1'b0;
    ln_en   = 1'b0;
    ln_clr  = 1'b0;
    unique case (st_q)
      WAIT_VS: begin
        if (in_vsync) st_d = BLANK;
      end
      BLANK: begin
        if (!in_vsync) begin
          st_d    = ACTIVE;
          line_d  = '0;
          pix_d   = '0;
          phase_d = 1'b0;
          err_d   = 1'b0;
          px_clr  = 1'b1;
          ln_clr  = 1'b1;
        end
      end
      ACTIVE: begin
        if (line_end) begin
          pix_d   = '0;
          phase_d = 1'b0;
          px_clr  = 1'b1;
          if (line_q != H_C) begin
            line_d = line_q + CW'(1);
            ln_en  = 1'b1;
          end
          if (phase_q || pix_q != W_C) err_d = 1'b1;
        end
        if (in_vsync) begin
          // VSYNC during a line aborts it; the byte is never forwarded
          st_d = END;
          if (in_href) err_d = 1'b1;
        end else if (in_href) begin
          phase_d = ~phase_q;
          if (pix_q >= W_C || line_q >= H_C) begin
            err_d = 1'b1;
          end else if (px_zero && ln_zero) begin
            oh_d = 1'b1;
            px_d = in_px_data;
          end
          if (phase_q && pix_q < W_C) begin
            pix_d = pix_q + CW'(1);
            px_en = 1'b1;
          end
        end
      end
      END: begin
        st_d = BLANK;
        if (line_q == H_C && !err_q) begin
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: st_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge CAM_pclk) begin
    if (reset) begin
      st_q    <= WAIT_VS;
      phase_q <= 1'b0;
      href_q  <= 1'b0;
      vs_q    <= 1'b1;
      px_q    <= '0;
      oh_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      line_q  <= '0;
      pix_q   <= '0;
    end else begin
      st_q    <= st_d;
      phase_q <= phase_d;
      href_q  <= in_href;
      vs_q    <= in_vsync;
      px_q    <= px_d;
      oh_q    <= oh_d;
      done_q  <= done_d;
      err_q   <= err_d;
      line_q  <= line_d;
      pix_q   <= pix_d;
    end
  end

  assign out_px_data = px_q;
  assign out_vsync   = vs_q;
  assign out_href    = oh_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign line_idx    = line_q;
  assign pix_idx     = pix_q;

endmodule

// File: tb/tb_cam_decimator.sv
// Scoreboard bench for cam_decimator on a reduced 40x24 source frame:
// the driver predicts kept bytes and frame_done pulses, a monitor checks them.
module tb_cam_decimator;

  localparam int W  = 40;
  localparam int H  = 24;
  localparam int DX = 4;
  localparam int DY = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_px_data;
  logic          in_vsync;
  logic          in_href;
  logic [7:0]    out_px_data;
  logic          out_vsync;
  logic          out_href;
  logic          frame_done;
  logic          frame_err;
  logic [CW-1:0] line_idx;
  logic [CW-1:0] pix_idx;

  cam_decimator #(
    .SRC_W(W), .SRC_H(H), .DEC_X(DX), .DEC_Y(DY), .CW(CW)
  ) dut (
    .CAM_pclk    (clk),
    .reset       (reset),
    .in_px_data  (in_px_data),
    .in_vsync    (in_vsync),
    .in_href     (in_href),
    .out_px_data (out_px_data),
    .out_vsync   (out_vsync),
    .out_href    (out_href),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .line_idx    (line_idx),
    .pix_idx     (pix_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t pxq[$];
  int   doneq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   armed = 1'b0;
  logic mon_v, mon_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    mon_v = in_vsync;
    mon_r = reset;
    #1;
    chk("vsync_lag", out_vsync, mon_r ? 1 : int'(mon_v));
    while (pxq.size() > 0 && pxq[0].c < cyc) begin
      chk("missing_pixel", pxq[0].c, -1);
      void'(pxq.pop_front());
    end
    if (out_href) begin
      if (pxq.size() == 0) begin
        chk("unexpected_href", cyc, -1);
      end else begin
        exp_t e;
        e = pxq.pop_front();
        chk("px_data", out_px_data, e.d);
        chk("px_cycle", cyc, e.c);
      end
    end
    while (doneq.size() > 0 && doneq[0] < cyc) begin
      chk("missing_done", doneq[0], -1);
      void'(doneq.pop_front());
    end
    if (frame_done) begin
      if (doneq.size() == 0) chk("unexpected_done", cyc, -1);
      else chk("done_cycle", cyc, doneq.pop_front());
    end
  end

  task automatic drive(input logic h, input logic v, input logic [7:0] d);
    @(negedge clk);
    reset      = 1'b0;
    in_href    = h;
    in_vsync   = v;
    in_px_data = d;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_href"}, out_href, 0);
    chk({tag, "_data"}, out_px_data, 0);
    chk({tag, "_vsync"}, out_vsync, 1);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_err"}, frame_err, 0);
    chk({tag, "_line"}, line_idx, 0);
    chk({tag, "_pix"}, pix_idx, 0);
  endtask

  task automatic reset_pulse(input logic [7:0] d);
    @(negedge clk);
    reset      = 1'b1;
    in_href    = 1'b1;
    in_vsync   = 1'b0;
    in_px_data = d;
    @(posedge clk);
    #1;
    check_reset_outs("midline_rst");
  endtask

  function automatic logic [7:0] pattern(input int b);
    logic [7:0] pb;
    pb = 8'(b / 2);
    return (b % 2 == 0) ? {4'hA, pb[3:0]} : pb;
  endfunction

  task automatic frame(input int odd_l, input int ext_l, input int ab_l,
                       input int ab_p, input int rs_l, input int rs_p,
                       input bit rnd);
    bit err;
    bit ab;
    int nb;
    int p;
    logic [7:0] d;
    err = 1'b0;
    ab  = 1'b0;
    repeat (3) drive(1'b0, 1'b1, 8'h00);
    armed = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    chk("err_clear_at_start", frame_err, 0);
    chk("line_zero_at_start", line_idx, 0);
    for (int l = 0; l < H && !ab; l++) begin
      nb = 2 * W;
      if (l == odd_l) nb = nb - 1;
      if (l == ext_l) nb = nb + 2;
      for (int b = 0; b < nb; b++) begin
        p = b / 2;
        d = rnd ? 8'($urandom) : pattern(b);
        if (l == ab_l && p == ab_p && b % 2 == 0) begin
          drive(1'b1, 1'b1, d);
          err = 1'b1;
          ab  = 1'b1;
          break;
        end
        if (l == rs_l && p == rs_p && b % 2 == 0) begin
          reset_pulse(d);
          armed = 1'b0;
          err   = 1'b0;
          continue;
        end
        drive(1'b1, 1'b0, d);
        if (armed && l % DY == 0 && p % DX == 0 && p < W)
          pxq.push_back('{d, cyc + 1});
        if (p >= W) err = 1'b1;
      end
      if (!ab) begin
        if (l == odd_l) err = 1'b1;
        repeat ($urandom_range(1, 4)) drive(1'b0, 1'b0, 8'h00);
      end
    end
    if (!ab) begin
      drive(1'b0, 1'b1, 8'h00);
      if (armed && !err) doneq.push_back(cyc + 2);
    end
    repeat (3) drive(1'b0, 1'b1, 8'h00);
    chk("frame_err_end", frame_err, armed ? int'(err) : 0);
    if (armed && !ab) chk("line_idx_end", line_idx, H);
  endtask

  initial begin
    reset      = 1'b1;
    in_href    = 1'b0;
    in_vsync   = 1'b0;
    in_px_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outs("por");

    // power-up inside active video: nothing forwarded before first VSYNC
    for (int l = 0; l < 3; l++) begin
      for (int b = 0; b < 2 * W; b++) drive(1'b1, 1'b0, pattern(b));
      repeat (3) drive(1'b0, 1'b0, 8'h00);
    end
    chk("startup_line_idx", line_idx, 0);
    chk("startup_href", out_href, 0);

    frame(-1, -1, -1, -1, -1, -1, 1'b0);
    frame(10, -1, -1, -1, -1, -1, 1'b0);
    frame(-1, -1, -1, -1, -1, -1, 1'b0);
    frame(-1, -1, 15, 20, -1, -1, 1'b0);
    frame(-1, -1, -1, -1, -1, -1, 1'b0);
    frame(-1, -1, -1, -1, 8, 12, 1'b0);
    frame(-1, -1, -1, -1, -1, -1, 1'b0);
    frame(-1, 7, -1, -1, -1, -1, 1'b0);
    for (int f = 0; f < 3; f++) frame(-1, -1, -1, -1, -1, -1, 1'b1);
    frame(int'($urandom_range(0, H - 1)), -1, -1, -1, -1, -1, 1'b1);
    frame(-1, -1, -1, -1, -1, -1, 1'b1);

    repeat (5) drive(1'b0, 1'b1, 8'h00);
    chk("pixel_queue_empty", pxq.size(), 0);
    chk("done_queue_empty", doneq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
